// File: rtl/jt12_modseq.sv
// Modulation sequencer for a 4-operator FM voice: walks the operator slots of a frame,
// keeps per-channel operator history and issues the routed modulation input for each slot.
module jt12_modseq #(
  parameter int NUM_CH = 6,
  parameter int OPW    = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cen,
  input  logic                  zero,
  input  logic signed [OPW-1:0] op_result,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_ch,
  input  logic [2:0]            cfg_alg,
  input  logic [2:0]            cfg_fb,
  output logic signed [OPW:0]   mod_out,
  output logic [1:0]            nxt_stage,
  output logic [2:0]            nxt_ch,
  output logic                  mod_valid
);

  typedef enum logic [1:0] {S1 = 2'd0, S2 = 2'd1, S3 = 2'd2, S4 = 2'd3} stage_t;

  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

  stage_t stage, stage_nx;
  logic [2:0] ch, ch_nx;

  // Storage is sized for the full 3-bit channel space; slots above NUM_CH-1 are never written.
  logic signed [OPW-1:0] hist   [4][8];
  logic signed [OPW-1:0] s1_old [8];
  logic [2:0]            alg    [8];
  logic [2:0]            fb     [8];

  // Frame order within a channel sweep is S1, S3, S2, S4.
  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    stage_nx = stage;
    ch_nx    = ch;
    if (zero) begin
      stage_nx = S1;
      ch_nx    = '0;
    end else if (ch < LAST_CH) begin
      ch_nx = ch + 3'd1;
    end else begin
      ch_nx = '0;
      unique case (stage)
        S1: stage_nx = S3;
        S3: stage_nx = S2;
        S2: stage_nx = S4;
        S4: stage_nx = S1;
      endcase
    end
  end

  // Operands for the next slot's channel, with this cycle's write bypassed in.
  logic signed [OPW-1:0] v1, v1_old, v2, v3;
  always_comb begin
    v1     = hist[S1][ch_nx];
    v1_old = s1_old[ch_nx];
    v2     = hist[S2][ch_nx];
    v3     = hist[S3][ch_nx];
    if (ch == ch_nx) begin
      unique case (stage)
        S1: begin
          v1_old = hist[S1][ch];
          v1     = op_result;
        end
        S2:      v2 = op_result;
        S3:      v3 = op_result;
        default: ;
      endcase
    end
  end

  logic signed [OPW:0] e1, e1_old, e2, e3, fb_sum, mod_nx;
  logic [2:0]          a, f;
  logic [3:0]          shamt;

  always_comb begin
    e1     = {v1[OPW-1], v1};
    e1_old = {v1_old[OPW-1], v1_old};
    e2     = {v2[OPW-1], v2};
    e3     = {v3[OPW-1], v3};
    a      = alg[ch_nx];
    f      = fb[ch_nx];
    shamt  = 4'd10 - {1'b0, f};
    fb_sum = e1 + e1_old;
    mod_nx = '0;
    unique case (stage_nx)
      S1: if (f != 3'd0) mod_nx = fb_sum >>> shamt;
      S2: begin
        case (a)
          3'd0, 3'd3, 3'd4, 3'd5, 3'd6: mod_nx = e1;
          default:                      mod_nx = '0;
        endcase
      end
      S3: begin
        case (a)
          3'd5:       mod_nx = e1;
          3'd0, 3'd2: mod_nx = e2;
          3'd1:       mod_nx = e1 + e2;
          default:    mod_nx = '0;
        endcase
      end
      S4: begin
        case (a)
          3'd5:             mod_nx = e1;
          3'd0, 3'd1, 3'd4: mod_nx = e3;
          3'd3:             mod_nx = e3 + e2;
          3'd2:             mod_nx = e3 + e1;
          default:          mod_nx = '0;
        endcase
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage     <= S1;
      ch        <= '0;
      mod_out   <= '0;
      mod_valid <= 1'b0;
    end else if (cen) begin
      stage     <= stage_nx;
      ch        <= ch_nx;
      mod_out   <= mod_nx;
      mod_valid <= 1'b1;
    end
  end

  // NOTE: history and config are small register files, so they take the async clear like any flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        s1_old[i] <= '0;
        alg[i]    <= '0;
        fb[i]     <= '0;
        for (int s = 0; s < 4; s++) hist[s][i] <= '0;
      end
    end else begin
      if (cen) begin
        hist[stage][ch] <= op_result;
        if (stage == S1) s1_old[ch] <= hist[S1][ch];
      end
      if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
        alg[cfg_ch] <= cfg_alg;
        fb[cfg_ch]  <= cfg_fb;
      end
    end
  end

  assign nxt_stage = stage;
  assign nxt_ch    = ch;

endmodule

// File: tb/tb_jt12_modseq.sv
// Bench for jt12_modseq: a six-channel and a one-channel instance share stimulus and are
// compared every cycle against a frame-position reference model.
module tb_jt12_modseq;

  localparam int OPW = 14;
  localparam int NCH [2] = '{6, 1};
  localparam int ORDER [4] = '{0, 2, 1, 3};

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cen = 1'b0;
  logic                  zero = 1'b0;
  logic signed [OPW-1:0] op_result = '0;
  logic                  cfg_we = 1'b0;
  logic [2:0]            cfg_ch = '0;
  logic [2:0]            cfg_alg = '0;
  logic [2:0]            cfg_fb = '0;

  logic signed [OPW:0] mod_a, mod_b;
  logic [1:0]          stage_a, stage_b;
  logic [2:0]          ch_a, ch_b;
  logic                valid_a, valid_b;

  jt12_modseq #(.NUM_CH(6), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .op_result(op_result),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_alg(cfg_alg), .cfg_fb(cfg_fb),
    .mod_out(mod_a), .nxt_stage(stage_a), .nxt_ch(ch_a), .mod_valid(valid_a)
  );

  jt12_modseq #(.NUM_CH(1), .OPW(OPW)) dut1 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .op_result(op_result),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_alg(cfg_alg), .cfg_fb(cfg_fb),
    .mod_out(mod_b), .nxt_stage(stage_b), .nxt_ch(ch_b), .mod_valid(valid_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: slot derived from a position counter within the frame.
  int m_hist [2][4][8];
  int m_old  [2][8];
  int m_alg  [2][8];
  int m_fb   [2][8];
  int m_pos  [2];
  int m_mod  [2];
  int m_valid;

  function automatic int slot_stage(input int k);
    return ORDER[m_pos[k] / NCH[k]];
  endfunction

  function automatic int slot_ch(input int k);
    return m_pos[k] % NCH[k];
  endfunction

  function automatic int route(input int k, input int st, input int c);
    int a, f, s1, s2, s3;
    a  = m_alg[k][c];
    f  = m_fb[k][c];
    s1 = m_hist[k][0][c];
    s2 = m_hist[k][1][c];
    s3 = m_hist[k][2][c];
    case (st)
      0: return (f == 0) ? 0 : ((s1 + m_old[k][c]) >>> (10 - f));
      1: return (a == 0 || a == 3 || a == 4 || a == 5 || a == 6) ? s1 : 0;
      2: begin
        if (a == 5) return s1;
        if (a == 0 || a == 2) return s2;
        if (a == 1) return s1 + s2;
        return 0;
      end
      default: begin
        if (a == 5) return s1;
        if (a == 0 || a == 1 || a == 4) return s3;
        if (a == 3) return s3 + s2;
        if (a == 2) return s3 + s1;
        return 0;
      end
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 8; c++) begin
        m_old[k][c] = 0;
        m_alg[k][c] = 0;
        m_fb[k][c]  = 0;
        for (int s = 0; s < 4; s++) m_hist[k][s][c] = 0;
      end
      m_pos[k] = 0;
      m_mod[k] = 0;
    end
    m_valid = 0;
  endtask

  task automatic model_clk();
    int st, c;
    for (int k = 0; k < 2; k++) begin
      if (cen) begin
        st = slot_stage(k);
        c  = slot_ch(k);
        if (st == 0) m_old[k][c] = m_hist[k][0][c];
        m_hist[k][st][c] = int'(op_result);
        m_pos[k] = zero ? 0 : (m_pos[k] + 1) % (4 * NCH[k]);
        m_mod[k] = route(k, slot_stage(k), slot_ch(k));
      end
      if (cfg_we && int'(cfg_ch) < NCH[k]) begin
        m_alg[k][cfg_ch] = int'(cfg_alg);
        m_fb[k][cfg_ch]  = int'(cfg_fb);
      end
    end
    if (cen) m_valid = 1;
  endtask

  task automatic check_outs();
    check("n6_stage", int'(stage_a), slot_stage(0));
    check("n6_ch",    int'(ch_a),    slot_ch(0));
    check("n6_mod",   int'(mod_a),   m_mod[0]);
    check("n6_valid", int'(valid_a), m_valid);
    check("n1_stage", int'(stage_b), slot_stage(1));
    check("n1_ch",    int'(ch_b),    slot_ch(1));
    check("n1_mod",   int'(mod_b),   m_mod[1]);
    check("n1_valid", int'(valid_b), m_valid);
  endtask

  function automatic int rnd_op();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  task automatic step(input bit c, input bit z, input int op);
    @(negedge clk);
    cen       = c;
    zero      = z;
    op_result = OPW'(op);
    cfg_we    = 1'b0;
    @(posedge clk);
    model_clk();
    #1 check_outs();
  endtask

  task automatic cfg(input int ch, input int alg, input int fbl);
    @(negedge clk);
    cen     = 1'b0;
    zero    = 1'b0;
    cfg_we  = 1'b1;
    cfg_ch  = 3'(ch);
    cfg_alg = 3'(alg);
    cfg_fb  = 3'(fbl);
    @(posedge clk);
    model_clk();
    #1 check_outs();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    cen    = 1'b0;
    zero   = 1'b0;
    cfg_we = 1'b0;
    #1;
    model_reset();
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_outs();
  endtask

  initial begin
    int op;
    model_reset();
    #12 rst_n = 1'b1;
    #1 check_outs();

    // Channel ch0 on algorithm 1: S3 = S1 + previous-frame S2; algorithm 7 silences S4.
    cfg(0, 1, 0);
    for (int k = 1; k <= 30; k++) begin
      op = (k == 1 || k == 25) ? 100 : (k == 13) ? -50 : (k == 7) ? 77 : rnd_op();
      step(1'b1, 1'b0, op);
      if (k == 24) begin
        check("order_wrap_stage", int'(stage_a), 0);
        check("order_wrap_ch", int'(ch_a), 0);
      end
    end
    check("alg1_s3_stage", int'(stage_a), 2);
    check("alg1_s3_mod", int'(mod_a), 50);
    cfg(0, 7, 0);
    for (int k = 31; k <= 42; k++) step(1'b1, 1'b0, (k == 31) ? 77 : rnd_op());
    check("alg7_s4_stage", int'(stage_a), 3);
    check("alg7_s4_mod", int'(mod_a), 0);

    // S1 self-feedback over two frames.
    do_reset();
    cfg(0, 0, 7);
    for (int k = 1; k <= 48; k++) begin
      step(1'b1, 1'b0, (k == 1 || k == 25) ? 1000 : rnd_op());
      if (k == 24) check("fb7_first", int'(mod_a), 125);
    end
    check("fb7_mod", int'(mod_a), 250);
    cfg(0, 0, 0);
    for (int k = 49; k <= 72; k++) step(1'b1, 1'b0, rnd_op());
    check("fb0_mod", int'(mod_a), 0);

    // Single-channel bypass: S1 written at this cen feeds the immediately issued S3.
    do_reset();
    cfg(0, 5, 0);
    step(1'b1, 1'b0, -8192);
    check("bypass_stage", int'(stage_b), 2);
    check("bypass_mod", int'(mod_b), -8192);

    // Resync at S2 ch3, then a stall with toggling inputs.
    do_reset();
    for (int k = 1; k <= 15; k++) step(1'b1, 1'b0, rnd_op());
    check("pre_sync_stage", int'(stage_a), 1);
    check("pre_sync_ch", int'(ch_a), 3);
    step(1'b1, 1'b1, rnd_op());
    check("sync_stage", int'(stage_a), 0);
    check("sync_ch", int'(ch_a), 0);
    for (int k = 0; k < 5; k++) step(1'b0, k[0], rnd_op());

    // Reset while the frame is at S4 ch2.
    for (int k = 1; k <= 20; k++) step(1'b1, 1'b0, rnd_op());
    check("pre_rst_stage", int'(stage_a), 3);
    check("pre_rst_ch", int'(ch_a), 2);
    do_reset();
    check("rst_valid", int'(valid_a), 0);
    check("rst_mod", int'(mod_a), 0);
    step(1'b1, 1'b0, rnd_op());
    check("post_rst_ch", int'(ch_a), 1);

    // Random traffic including same-cycle config writes and out-of-range channels.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      cen       = 1'($urandom_range(0, 1));
      zero      = ($urandom_range(0, 31) == 0);
      op_result = OPW'(rnd_op());
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_ch    = 3'($urandom_range(0, 7));
      cfg_alg   = 3'($urandom_range(0, 7));
      cfg_fb    = 3'($urandom_range(0, 7));
      @(posedge clk);
      model_clk();
      #1 check_outs();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jt12_modseq.md
JT12_MODSEQ -- requirements
Module: jt12_modseq

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, channels per frame, legal range 1..8.
REQ-002 SHALL have parameter OPW, default 14, operator output width (signed).
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cen, input, 1, slot-advance enable; no slot state changes when low.
REQ-006 SHALL have port zero, input, 1, frame resync; sampled only when cen=1.
REQ-007 SHALL have port op_result, input, OPW, signed output of the current slot; sampled when cen=1.
REQ-008 SHALL have port cfg_we, input, 1, config write strobe; active regardless of cen.
REQ-009 SHALL have port cfg_ch, input, 3, target channel of the config write.
REQ-010 SHALL have port cfg_alg, input, 3, algorithm 0..7 to store for cfg_ch.
REQ-011 SHALL have port cfg_fb, input, 3, S1 feedback level to store for cfg_ch.
REQ-012 SHALL have port mod_out, output, OPW+1, signed registered modulation for the issued slot.
REQ-013 SHALL have port nxt_stage, output, 2, operator of the issued slot: S1=0, S2=1, S3=2, S4=3.
REQ-014 SHALL have port nxt_ch, output, 3, channel of the issued slot.
REQ-015 SHALL have port mod_valid, output, 1, high once the first slot has been issued after reset.

Function
REQ-016 SHALL track the current slot (stage, ch); slot order is S1 for ch 0..NUM_CH-1, then S3, S2, S4, then wrap to S1 ch0.
REQ-017 SHALL, on cen=1, write op_result into hist[stage][ch] of the current slot; for S1 it first shifts the old value into s1_old[ch].
REQ-018 SHALL, on cen=1, advance to the next slot; with zero=1 the next slot is forced to (S1, ch0) and the current write still happens.
REQ-019 SHALL, on cen=1, register mod_out, nxt_stage and nxt_ch for the new slot, and set mod_valid=1.
REQ-020 SHALL compute mod_out from the history plus the op_result being written that cycle (bypass), so a value written at cen is visible to the very next slot.
REQ-021 SHALL route S1: fb=0 gives 0; otherwise mod_out = (hist S1 + s1_old) >>> (10-fb), summed in OPW+1 bits before the arithmetic shift.
REQ-022 SHALL route S2: S1 for alg 0,3,4,5,6; 0 otherwise.
REQ-023 SHALL route S3: S1 for alg 5; S2 for alg 0,2; S1+S2 for alg 1; 0 for alg 3,4,6,7.
REQ-024 SHALL route S4: S1 for alg 5; S3 for alg 0,1,4; S3+S2 for alg 3; S3+S1 for alg 2; 0 for alg 6,7.
REQ-025 SHALL sign-extend every operand to OPW+1 bits; the two-term sums SHALL neither saturate nor overflow.
REQ-026 SHALL use the same-frame value for a routed operand if it was written earlier in the frame, and the previous-frame value otherwise; S2 feeding S3 therefore always uses the previous frame.
REQ-027 SHALL store cfg_alg and cfg_fb on any clk with cfg_we=1; a write in the same cycle as a cen SHALL NOT affect that cen's mod_out.
REQ-028 SHALL ignore a config write with cfg_ch >= NUM_CH.
REQ-029 SHALL hold all slot state and outputs while cen=0, even if zero or op_result toggle.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously clear hist, s1_old, alg, fb, mod_out and mod_valid to 0, and set the current slot and nxt_stage/nxt_ch to (S1, ch0).
REQ-031 SHALL, on reset assertion mid-frame, abandon the frame; the first cen after release writes slot (S1, ch0).

Verification
REQ-032 Order: NUM_CH=6, 24 cen pulses with zero=0 -> nxt_stage/nxt_ch run S1 ch1..5, S3 ch0..5, S2 ch0..5, S4 ch0..5, S1 ch0.
REQ-033 Alg 1, ch0: S1=100, S2 (previous frame)=-50 -> S3 ch0 mod_out=50; alg 7 -> S4 mod_out=0.
REQ-034 Feedback: fb=7, S1 writes 1000 then 1000 -> next S1 ch0 mod_out=(2000)>>>3=250; fb=0 -> 0.
REQ-035 Bypass: NUM_CH=1, alg 5, write S1=-8192 at cen -> the immediately issued S3 mod_out=-8192.
REQ-036 Resync and stall: zero=1 with cen while at S2 ch3 -> next slot is (S1, ch0); 5 cycles of cen=0 with toggling op_result -> outputs unchanged.
REQ-037 Reset mid-frame at S4 ch2 -> all outputs 0, slot (S1, ch0), mod_valid=0 until the next cen.
